// File: rtl/gb_sched_pkg.sv
// Shared state encodings for the GB bank rotation scheduler.
package gb_sched_pkg;

    // Life cycle of one GB bank as it moves around the ring.
    typedef enum logic [2:0] {
        BANK_FREE,
        BANK_LOADING,
        BANK_READY,
        BANK_COMPUTING,
        BANK_DIRTY,
        BANK_DONE
    } bank_state_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_REQ,
        LD_DATA
    } ld_state_t;

    typedef enum logic {
        CMP_IDLE,
        CMP_RUN
    } cmp_state_t;

    typedef enum logic {
        RET_IDLE,
        RET_WB
    } ret_state_t;

endpackage

// File: rtl/gb_beat_ctr.sv
// Beat index counter for one DRAM burst: clear, increment with wrap, last flag.
module gb_beat_ctr #(
    parameter int BEATS  = 8,
    parameter int BEAT_W = $clog2(BEATS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [BEAT_W-1:0] beat_o,
    output logic              last_o
);

    logic [BEAT_W-1:0] beat_q;
    logic [BEAT_W-1:0] beat_d;

    // Next beat: clear wins over increment; BEATS is a power of two so +1 wraps.
    always_comb begin
        // NOTE: default assignment first so every path drives beat_d and no latch is inferred.
        beat_d = beat_q;
        if (clr_i) begin
            beat_d = '0;
        end else if (inc_i) begin
            beat_d = beat_q + BEAT_W'(1);
        end
    end

    // Beat register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignment so all flops sample pre-edge values together.
        if (!reset_n) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end

    assign beat_o = beat_q;
    assign last_o = (beat_q == BEAT_W'(BEATS - 1));

endmodule

// File: rtl/gb_bank_sched.sv
// N-bank ring scheduler: load, compute and retire FSMs chase each other around
// the GB banks so DRAM fetch, MAC compute and writeback overlap on distinct banks.
module gb_bank_sched #(
    parameter int NUM_BANKS = 3,
    parameter int BEATS     = 8,
    parameter int ADDR_W    = 28,
    parameter int BANK_W    = $clog2(NUM_BANKS),
    parameter int BEAT_W    = $clog2(BEATS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              node_valid,
    output logic              node_ready,
    input  logic [ADDR_W-1:0] node_rd_addr,
    input  logic              node_wb_en,
    input  logic [ADDR_W-1:0] node_wb_addr,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    output logic              ld_we,
    output logic [BANK_W-1:0] ld_bank,
    output logic [BEAT_W-1:0] ld_beat,
    output logic              cmp_start,
    output logic [BANK_W-1:0] cmp_bank,
    input  logic              cmp_done,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_gnt,
    output logic              wb_re,
    output logic [BANK_W-1:0] wb_bank,
    output logic [BEAT_W-1:0] wb_beat,
    output logic              busy
);

    import gb_sched_pkg::*;

    // Per-bank state and writeback descriptor.
    bank_state_t       bank_q    [NUM_BANKS];
    bank_state_t       bank_d    [NUM_BANKS];
    logic              wb_en_q   [NUM_BANKS];
    logic              wb_en_d   [NUM_BANKS];
    logic [ADDR_W-1:0] wb_addr_q [NUM_BANKS];
    logic [ADDR_W-1:0] wb_addr_d [NUM_BANKS];

    // FSM state and ring pointers.
    ld_state_t         ld_state_q, ld_state_d;
    cmp_state_t        cmp_state_q, cmp_state_d;
    ret_state_t        ret_state_q, ret_state_d;
    logic [BANK_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [BANK_W-1:0] cmp_ptr_q, cmp_ptr_d;
    logic [BANK_W-1:0] ret_ptr_q, ret_ptr_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              cmp_start_q, cmp_start_d;
    logic              wb_first_q, wb_first_d;

    // Beat counter controls.
    logic              ld_clr, ld_last;
    logic              ret_clr, ret_inc, ret_last;
    logic [BEAT_W-1:0] ret_beat;

    function automatic logic [BANK_W-1:0] next_ptr(input logic [BANK_W-1:0] p);
        return (p == BANK_W'(NUM_BANKS - 1)) ? '0 : p + BANK_W'(1);
    endfunction

    assign node_ready = (ld_state_q == LD_IDLE) && (bank_q[ld_ptr_q] == BANK_FREE);
    assign rd_req     = (ld_state_q == LD_REQ);
    assign rd_addr    = rd_addr_q;
    assign ld_we      = (ld_state_q == LD_DATA) && rd_valid;
    assign ld_bank    = ld_ptr_q;
    assign cmp_start  = cmp_start_q;
    assign cmp_bank   = cmp_ptr_q;
    assign wr_req     = (ret_state_q == RET_WB);
    assign wr_addr    = wr_req ? (wb_addr_q[ret_ptr_q] + ADDR_W'(ret_beat)) : '0;
    assign wb_re      = wr_req && wb_first_q;
    assign wb_bank    = ret_ptr_q;
    assign wb_beat    = ret_beat;

    assign ld_clr  = (ld_state_q == LD_REQ) && rd_gnt;
    assign ret_inc = wr_req && wr_gnt;

    gb_beat_ctr #(.BEATS(BEATS), .BEAT_W(BEAT_W)) u_ld_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (ld_clr),
        .inc_i   (ld_we),
        .beat_o  (ld_beat),
        .last_o  (ld_last)
    );

    gb_beat_ctr #(.BEATS(BEATS), .BEAT_W(BEAT_W)) u_ret_ctr (
        .clock   (clock),
        .reset_n (reset_n),
        .clr_i   (ret_clr),
        .inc_i   (ret_inc),
        .beat_o  (ret_beat),
        .last_o  (ret_last)
    );

    // Next state of the three FSMs; ring ordering keeps their bank updates disjoint.
    always_comb begin
        bank_d      = bank_q;
        wb_en_d     = wb_en_q;
        wb_addr_d   = wb_addr_q;
        ld_state_d  = ld_state_q;
        cmp_state_d = cmp_state_q;
        ret_state_d = ret_state_q;
        ld_ptr_d    = ld_ptr_q;
        cmp_ptr_d   = cmp_ptr_q;
        ret_ptr_d   = ret_ptr_q;
        rd_addr_d   = rd_addr_q;
        cmp_start_d = 1'b0;
        wb_first_d  = wb_first_q;
        ret_clr     = 1'b0;

        // Load: accept node, request burst, stream beats into the bank.
        case (ld_state_q)
            LD_IDLE: begin
                if (node_valid && node_ready) begin
                    rd_addr_d           = node_rd_addr;
                    wb_en_d[ld_ptr_q]   = node_wb_en;
                    wb_addr_d[ld_ptr_q] = node_wb_addr;
                    bank_d[ld_ptr_q]    = BANK_LOADING;
                    ld_state_d          = LD_REQ;
                end
            end
            LD_REQ: begin
                if (rd_gnt) ld_state_d = LD_DATA;
            end
            LD_DATA: begin
                if (rd_valid && ld_last) begin
                    bank_d[ld_ptr_q] = BANK_READY;
                    ld_ptr_d         = next_ptr(ld_ptr_q);
                    ld_state_d       = LD_IDLE;
                end
            end
            default: ld_state_d = LD_IDLE;
        endcase

        // Compute: launch on the next READY bank, wait for done.
        case (cmp_state_q)
            CMP_IDLE: begin
                if (bank_q[cmp_ptr_q] == BANK_READY) begin
                    cmp_start_d       = 1'b1;
                    bank_d[cmp_ptr_q] = BANK_COMPUTING;
                    cmp_state_d       = CMP_RUN;
                end
            end
            CMP_RUN: begin
                if (cmp_done) begin
                    bank_d[cmp_ptr_q] = wb_en_q[cmp_ptr_q] ? BANK_DIRTY : BANK_DONE;
                    cmp_ptr_d         = next_ptr(cmp_ptr_q);
                    cmp_state_d       = CMP_IDLE;
                end
            end
            default: cmp_state_d = CMP_IDLE;
        endcase

        // Retire: free clean banks at once, write dirty banks back beat by beat.
        case (ret_state_q)
            RET_IDLE: begin
                if (bank_q[ret_ptr_q] == BANK_DONE) begin
                    bank_d[ret_ptr_q] = BANK_FREE;
                    ret_ptr_d         = next_ptr(ret_ptr_q);
                end else if (bank_q[ret_ptr_q] == BANK_DIRTY) begin
                    ret_clr     = 1'b1;
                    wb_first_d  = 1'b1;
                    ret_state_d = RET_WB;
                end
            end
            RET_WB: begin
                if (wr_gnt) begin
                    wb_first_d = !ret_last;
                    if (ret_last) begin
                        bank_d[ret_ptr_q] = BANK_FREE;
                        ret_ptr_d         = next_ptr(ret_ptr_q);
                        ret_state_d       = RET_IDLE;
                    end
                end else begin
                    wb_first_d = 1'b0;
                end
            end
            default: ret_state_d = RET_IDLE;
        endcase
    end

    // State registers; reset returns every bank to FREE and drops in-flight beats.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            // NOTE: the per-bank descriptor is reset too, so wr_addr never shows stale data after reset.
            for (int i = 0; i < NUM_BANKS; i++) begin
                bank_q[i]    <= BANK_FREE;
                wb_en_q[i]   <= 1'b0;
                wb_addr_q[i] <= '0;
            end
            ld_state_q  <= LD_IDLE;
            cmp_state_q <= CMP_IDLE;
            ret_state_q <= RET_IDLE;
            ld_ptr_q    <= '0;
            cmp_ptr_q   <= '0;
            ret_ptr_q   <= '0;
            rd_addr_q   <= '0;
            cmp_start_q <= 1'b0;
            wb_first_q  <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            wb_en_q     <= wb_en_d;
            wb_addr_q   <= wb_addr_d;
            ld_state_q  <= ld_state_d;
            cmp_state_q <= cmp_state_d;
            ret_state_q <= ret_state_d;
            ld_ptr_q    <= ld_ptr_d;
            cmp_ptr_q   <= cmp_ptr_d;
            ret_ptr_q   <= ret_ptr_d;
            rd_addr_q   <= rd_addr_d;
            cmp_start_q <= cmp_start_d;
            wb_first_q  <= wb_first_d;
        end
    end

    // Scheduler is busy while any bank holds a node.
    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            busy = busy | (bank_q[i] != BANK_FREE);
        end
    end

endmodule

// File: tb/tb_gb_bank_sched.sv
// Directed bench for gb_bank_sched (NUM_BANKS=3, BEATS=8): inputs change on the
// falling edge, outputs are checked on the falling edge or 1 time unit later.
module tb_gb_bank_sched;

    localparam int NUM_BANKS = 3;
    localparam int BEATS     = 8;
    localparam int ADDR_W    = 28;
    localparam int BANK_W    = 2;
    localparam int BEAT_W    = 3;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              node_valid;
    logic              node_ready;
    logic [ADDR_W-1:0] node_rd_addr;
    logic              node_wb_en;
    logic [ADDR_W-1:0] node_wb_addr;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic              rd_valid;
    logic              ld_we;
    logic [BANK_W-1:0] ld_bank;
    logic [BEAT_W-1:0] ld_beat;
    logic              cmp_start;
    logic [BANK_W-1:0] cmp_bank;
    logic              cmp_done;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_gnt;
    logic              wb_re;
    logic [BANK_W-1:0] wb_bank;
    logic [BEAT_W-1:0] wb_beat;
    logic              busy;

    int checks   = 0;
    int failures = 0;

    gb_bank_sched #(
        .NUM_BANKS (NUM_BANKS),
        .BEATS     (BEATS),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .node_valid   (node_valid),
        .node_ready   (node_ready),
        .node_rd_addr (node_rd_addr),
        .node_wb_en   (node_wb_en),
        .node_wb_addr (node_wb_addr),
        .rd_req       (rd_req),
        .rd_addr      (rd_addr),
        .rd_gnt       (rd_gnt),
        .rd_valid     (rd_valid),
        .ld_we        (ld_we),
        .ld_bank      (ld_bank),
        .ld_beat      (ld_beat),
        .cmp_start    (cmp_start),
        .cmp_bank     (cmp_bank),
        .cmp_done     (cmp_done),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_gnt       (wr_gnt),
        .wb_re        (wb_re),
        .wb_bank      (wb_bank),
        .wb_beat      (wb_beat),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".rd_req"},    32'(rd_req),    32'd0);
        check({tag, ".rd_addr"},   32'(rd_addr),   32'd0);
        check({tag, ".ld_we"},     32'(ld_we),     32'd0);
        check({tag, ".ld_bank"},   32'(ld_bank),   32'd0);
        check({tag, ".ld_beat"},   32'(ld_beat),   32'd0);
        check({tag, ".cmp_start"}, 32'(cmp_start), 32'd0);
        check({tag, ".cmp_bank"},  32'(cmp_bank),  32'd0);
        check({tag, ".wr_req"},    32'(wr_req),    32'd0);
        check({tag, ".wr_addr"},   32'(wr_addr),   32'd0);
        check({tag, ".wb_re"},     32'(wb_re),     32'd0);
        check({tag, ".wb_bank"},   32'(wb_bank),   32'd0);
        check({tag, ".wb_beat"},   32'(wb_beat),   32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
    endtask

    task automatic do_reset();
        reset_n      = 1'b0;
        node_valid   = 1'b0;
        node_rd_addr = '0;
        node_wb_en   = 1'b0;
        node_wb_addr = '0;
        rd_gnt       = 1'b0;
        rd_valid     = 1'b0;
        cmp_done     = 1'b0;
        wr_gnt       = 1'b0;
        tick();
        tick();
        check_idle("rst");
        reset_n = 1'b1;
        #1;
        check("rst.node_ready", 32'(node_ready), 32'd1);
    endtask

    // Accept one node, grant the burst after gnt_dly cycles, stream all beats.
    // Returns on the falling edge right after the last beat was sampled.
    task automatic load_node(input logic [ADDR_W-1:0] ra, input logic we,
                             input logic [ADDR_W-1:0] wa, input int gnt_dly,
                             input int bank);
        check("ld.node_ready", 32'(node_ready), 32'd1);
        node_valid   = 1'b1;
        node_rd_addr = ra;
        node_wb_en   = we;
        node_wb_addr = wa;
        tick();
        node_valid = 1'b0;
        #1;
        check("ld.rd_req", 32'(rd_req), 32'd1);
        check("ld.rd_addr", 32'(rd_addr), 32'(ra));
        repeat (gnt_dly) tick();
        check("ld.rd_req_held", 32'(rd_req), 32'd1);
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        for (int i = 0; i < BEATS; i++) begin
            rd_valid = 1'b1;
            #1;
            check("ld.we", 32'(ld_we), 32'd1);
            check("ld.beat", 32'(ld_beat), 32'(i));
            check("ld.bank", 32'(ld_bank), 32'(bank));
            tick();
        end
        rd_valid = 1'b0;
        #1;
        check("ld.we_off", 32'(ld_we), 32'd0);
    endtask

    initial begin
        // Single clean node, grant two cycles after the request.
        do_reset();
        load_node(28'h100, 1'b0, 28'h0, 2, 0);
        check("t1.start_early", 32'(cmp_start), 32'd0);
        tick();
        check("t1.start", 32'(cmp_start), 32'd1);
        check("t1.cmp_bank", 32'(cmp_bank), 32'd0);
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        check("t1.start_pulse", 32'(cmp_start), 32'd0);
        check("t1.busy_done", 32'(busy), 32'd1);
        tick();
        check("t1.busy_free", 32'(busy), 32'd0);
        check("t1.node_ready", 32'(node_ready), 32'd1);
        check("t1.ld_ptr", 32'(ld_bank), 32'd1);
        // Spurious done while compute is idle leaves the pointer alone.
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        tick();
        check("t6.cmp_ptr", 32'(cmp_bank), 32'd1);
        check("t6.start", 32'(cmp_start), 32'd0);
        check("t6.busy", 32'(busy), 32'd0);

        // Fill the ring with compute stalled; fourth node waits, then wraps to bank 0.
        do_reset();
        load_node(28'h1000, 1'b0, 28'h0, 0, 0);
        load_node(28'h1100, 1'b0, 28'h0, 0, 1);
        load_node(28'h1200, 1'b0, 28'h0, 0, 2);
        tick();
        check("t2.full", 32'(node_ready), 32'd0);
        node_valid   = 1'b1;
        node_rd_addr = 28'h1300;
        tick();
        check("t2.no_req0", 32'(rd_req), 32'd0);
        tick();
        check("t2.no_req1", 32'(rd_req), 32'd0);
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        check("t2.still_full", 32'(node_ready), 32'd0);
        tick();
        check("t2.ready_again", 32'(node_ready), 32'd1);
        check("t2.start_b1", 32'(cmp_start), 32'd1);
        check("t2.cmp_bank", 32'(cmp_bank), 32'd1);
        tick();
        node_valid = 1'b0;
        check("t2.rd_req4", 32'(rd_req), 32'd1);
        check("t2.rd_addr4", 32'(rd_addr), 32'h1300);
        rd_gnt = 1'b1;
        tick();
        rd_gnt   = 1'b0;
        rd_valid = 1'b1;
        #1;
        check("t2.wrap_we", 32'(ld_we), 32'd1);
        check("t2.wrap_bank", 32'(ld_bank), 32'd0);
        tick();
        rd_valid = 1'b0;

        // Writeback node with a grant every other cycle.
        do_reset();
        load_node(28'h200, 1'b1, 28'h2000, 1, 0);
        tick();
        check("t3.start", 32'(cmp_start), 32'd1);
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        tick();
        for (int i = 0; i < BEATS; i++) begin
            check("t3.wr_req", 32'(wr_req), 32'd1);
            check("t3.wb_re", 32'(wb_re), 32'd1);
            check("t3.wr_addr", 32'(wr_addr), 32'h2000 + 32'(i));
            check("t3.wb_beat", 32'(wb_beat), 32'(i));
            check("t3.wb_bank", 32'(wb_bank), 32'd0);
            tick();
            wr_gnt = 1'b1;
            #1;
            check("t3.wb_re_held", 32'(wb_re), 32'd0);
            check("t3.wr_req_held", 32'(wr_req), 32'd1);
            tick();
            wr_gnt = 1'b0;
        end
        check("t3.busy_free", 32'(busy), 32'd0);
        check("t3.wr_req_off", 32'(wr_req), 32'd0);
        check("t3.ret_ptr", 32'(wb_bank), 32'd1);

        // Overlap: bank0 writes back, bank1 computes, bank2 loads; all three events coincide.
        do_reset();
        load_node(28'h300, 1'b1, 28'h4000, 0, 0);
        tick();
        check("t4.start_b0", 32'(cmp_start), 32'd1);
        load_node(28'h400, 1'b0, 28'h0, 0, 1);
        cmp_done = 1'b1;
        tick();
        cmp_done = 1'b0;
        tick();
        check("t4.wr_req", 32'(wr_req), 32'd1);
        check("t4.wb_re", 32'(wb_re), 32'd1);
        check("t4.wr_addr0", 32'(wr_addr), 32'h4000);
        check("t4.start_b1", 32'(cmp_start), 32'd1);
        check("t4.cmp_bank1", 32'(cmp_bank), 32'd1);
        check("t4.node_ready", 32'(node_ready), 32'd1);
        node_valid   = 1'b1;
        node_rd_addr = 28'h500;
        node_wb_en   = 1'b1;
        node_wb_addr = 28'h6000;
        tick();
        node_valid = 1'b0;
        check("t4.rd_req", 32'(rd_req), 32'd1);
        rd_gnt = 1'b1;
        tick();
        rd_gnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_valid = 1'b1;
            tick();
        end
        cmp_done = 1'b1;
        wr_gnt   = 1'b1;
        #1;
        check("t4.same.ld_we", 32'(ld_we), 32'd1);
        check("t4.same.ld_beat", 32'(ld_beat), 32'd3);
        check("t4.same.ld_bank", 32'(ld_bank), 32'd2);
        check("t4.same.wb_beat", 32'(wb_beat), 32'd0);
        check("t4.same.cmp_bank", 32'(cmp_bank), 32'd1);
        tick();
        cmp_done = 1'b0;
        #1;
        check("t4.after.ld_beat", 32'(ld_beat), 32'd4);
        check("t4.after.wb_beat", 32'(wb_beat), 32'd1);
        check("t4.after.wr_addr", 32'(wr_addr), 32'h4001);
        check("t4.after.wb_re", 32'(wb_re), 32'd1);
        check("t4.after.cmp_bank", 32'(cmp_bank), 32'd2);
        check("t4.after.cmp_start", 32'(cmp_start), 32'd0);
        for (int i = 4; i < BEATS; i++) tick();
        rd_valid = 1'b0;
        #1;
        check("t4.ld_done_we", 32'(ld_we), 32'd0);
        check("t4.wb_beat5", 32'(wb_beat), 32'd5);
        check("t4.start_b2_early", 32'(cmp_start), 32'd0);
        tick();
        check("t4.start_b2", 32'(cmp_start), 32'd1);
        check("t4.cmp_bank2", 32'(cmp_bank), 32'd2);
        tick();
        check("t4.wb_beat7", 32'(wb_beat), 32'd7);
        check("t4.wr_addr7", 32'(wr_addr), 32'h4007);
        tick();
        wr_gnt = 1'b0;
        #1;
        check("t4.wr_req_off", 32'(wr_req), 32'd0);
        check("t4.ret_ptr1", 32'(wb_bank), 32'd1);
        check("t4.busy", 32'(busy), 32'd1);
        tick();
        check("t4.ret_ptr2", 32'(wb_bank), 32'd2);
        check("t4.ld_wrap", 32'(ld_bank), 32'd0);
        check("t4.node_ready_end", 32'(node_ready), 32'd1);

        // Reset in the middle of a burst, with a stray beat around the release.
        do_reset();
        node_valid   = 1'b1;
        node_rd_addr = 28'h700;
        tick();
        node_valid = 1'b0;
        rd_gnt     = 1'b1;
        tick();
        rd_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_valid = 1'b1;
            tick();
        end
        check("t5.mid_beat", 32'(ld_beat), 32'd4);
        reset_n = 1'b0;
        tick();
        check_idle("t5.rst");
        reset_n = 1'b1;
        #1;
        check("t5.node_ready", 32'(node_ready), 32'd1);
        check("t5.stray_we", 32'(ld_we), 32'd0);
        tick();
        check("t5.stray_beat", 32'(ld_beat), 32'd0);
        check("t5.stray_busy", 32'(busy), 32'd0);
        check("t5.stray_req", 32'(rd_req), 32'd0);
        check("t5.ptr", 32'(ld_bank), 32'd0);
        rd_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gb_bank_sched.md
Name: gb_bank_sched

Overview:
- Parametrised N-bank rotation scheduler between DRAM and the global buffer (GB). Generalises two-/three-bank ping-pong to NUM_BANKS banks in a ring.
- Three independent FSMs (load, compute, retire/writeback) overlap DRAM fetch, MAC compute and DRAM writeback across different banks.
- Sits between the DRAM controller port and the GB bank arrays; the compute engine sees only start/done per node.

Parameters:
- NUM_BANKS, 3, GB banks in rotation ring (>=2).
- BEATS, 8, DRAM beats per node burst (>=2, power of 2).
- ADDR_W, 28, DRAM address width.
- BANK_W, $clog2(NUM_BANKS), bank index width (derived).
- BEAT_W, $clog2(BEATS), beat index width (derived).

Ports:
- clock  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- node_valid  in  1  new node request.
- node_ready  out  1  scheduler accepts node this cycle.
- node_rd_addr  in  ADDR_W  DRAM load base address.
- node_wb_en  in  1  node result needs writeback.
- node_wb_addr  in  ADDR_W  DRAM writeback base address.
- rd_req  out  1  DRAM read burst request.
- rd_addr  out  ADDR_W  burst base address.
- rd_gnt  in  1  read burst accepted.
- rd_valid  in  1  read beat valid.
- ld_we  out  1  GB write strobe (combinational = rd_valid in LD_DATA).
- ld_bank  out  BANK_W  GB bank being loaded.
- ld_beat  out  BEAT_W  GB row within bank.
- cmp_start  out  1  one-cycle pulse, start compute.
- cmp_bank  out  BANK_W  bank computed on (stable while CMP_RUN).
- cmp_done  in  1  compute finished pulse.
- wr_req  out  1  DRAM write beat request.
- wr_addr  out  ADDR_W  node_wb_addr + beat.
- wr_gnt  in  1  write beat accepted.
- wb_re  out  1  GB read strobe for writeback beat.
- wb_bank  out  BANK_W  bank being written back.
- wb_beat  out  BEAT_W  beat index.
- busy  out  1  any bank not FREE.

Behaviour:
- Reset: all banks FREE; ld_ptr, cmp_ptr, ret_ptr = 0; all FSMs IDLE; every output 0 except node_ready, which is combinational and therefore 1 once reset is released.
- Reset mid-operation: beats in flight are dropped; rd_valid and wr_gnt are ignored while the FSMs are idle.
- Per-bank state: FREE, LOADING, READY, COMPUTING, DIRTY, DONE. Each bank also holds per-bank registers wb_en and wb_addr.
- Pointers advance mod NUM_BANKS, so bank order is strictly in-order.
- node_ready = (ld_fsm==LD_IDLE) && bank[ld_ptr]==FREE.
- Load FSM: LD_IDLE, LD_REQ, LD_DATA.
  - Accept (node_valid && node_ready): latch rd_addr, wb_en, wb_addr; bank -> LOADING; go to LD_REQ. rd_req is high the next cycle.
  - LD_REQ: rd_req held until rd_gnt, then LD_DATA with beat=0.
  - LD_DATA: each rd_valid writes ld_beat and increments the beat counter.
  - Last beat (BEATS-1): bank -> READY, ld_ptr++, LD_IDLE. A new node is acceptable the cycle after the last beat.
- Compute FSM: CMP_IDLE, CMP_RUN.
  - CMP_IDLE with bank[cmp_ptr]==READY: register cmp_start=1 for exactly one cycle, bank -> COMPUTING, CMP_RUN.
  - Latency: last load beat at cycle L gives cmp_start at L+2.
  - cmp_done in CMP_RUN: bank -> DIRTY if wb_en else DONE; cmp_ptr++; CMP_IDLE.
  - cmp_done in CMP_IDLE is ignored.
- Retire FSM: RET_IDLE, RET_WB.
  - bank[ret_ptr]==DONE: bank -> FREE, ret_ptr++ (one cycle).
  - bank[ret_ptr]==DIRTY: RET_WB with beat=0. wr_req=1; wb_re=1 on the cycle the request is first presented for each beat.
  - Each wr_gnt advances the beat. The grant of beat BEATS-1 sets bank FREE, ret_ptr++, RET_IDLE.
- Simultaneous events: state updates from different FSMs target distinct banks by construction. Ring ordering ld_ptr → cmp_ptr → ret_ptr guarantees this.
- Full condition: bank[ld_ptr]!=FREE deasserts node_ready.
- Empty condition: the compute FSM idles.
- NUM_BANKS=2 degenerates to ping-pong with identical rules.
- busy = OR over banks of (state!=FREE).

Decomposition:
- Package gb_sched_pkg holds bank_state_t, ld_state_t, cmp_state_t and ret_state_t enums.
- Sub-module gb_beat_ctr (parametrised BEATS wrap counter with clear/inc/last) is instantiated in the load and retire FSMs.

Test Plan:
- Single node, wb_en=0, rd_addr=0x100, rd_gnt 2 cycles after rd_req, BEATS=8 back-to-back rd_valid:
  - ld_we 8 cycles with ld_beat 0..7 on bank 0.
  - cmp_start exactly 2 cycles after the last beat with cmp_bank=0.
  - After cmp_done, bank 0 is FREE and busy=0.
- Four nodes, NUM_BANKS=3, cmp_done held off:
  - node_ready drops after 3 accepts.
  - The 4th node is accepted only after the first cmp_done plus retire; it loads into bank 0 (wrap).
- Writeback node, wb_addr=0x2000, wr_gnt every other cycle:
  - wr_addr steps 0x2000..0x2007; wb_beat 0..7 on the correct bank.
  - The bank becomes FREE the cycle after the 8th grant.
- Overlap case:
  - Node1 computing while node2 loads and node0 writes back: rd_valid, cmp_done and wr_gnt arrive in the same cycle.
  - All three banks update correctly with no lost beat.
- Reset asserted mid-LD_DATA after beat 3:
  - All outputs 0, node_ready=1 the cycle after reset release, pointers 0.
  - Stray rd_valid is ignored (no ld_we).
- Spurious cmp_done in CMP_IDLE: no state change, cmp_ptr unchanged.
